// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment display path.
// Segment vectors are ordered gfedcba and are active-low.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  localparam logic [6:0] SEG_CODE [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
  };

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low 7-segment decoder (gfedcba). Values above 9 blank the
// digit rather than lighting every segment.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (i_bcd <= 4'd9) begin
      o_seg = SEG_CODE[i_bcd];
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode scan controller with a frame-stable shadow of the
// BCD word. Optional leading-zero suppression: define SEG_LZ_BLANK_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 16,
  parameter int CNT_W     = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] digits,
  output logic [6:0]  y,
  output logic [3:0]  control,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] B_LAST = CNT_W'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);

  scan_state_t      r_state;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_shadow;
  logic [6:0]       r_y;
  logic [3:0]       r_control;
  logic             r_frame_done;

  scan_state_t      w_state_next;
  logic [1:0]       w_idx_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [15:0]      w_shadow_next;
  logic             w_frame_done_next;
  logic             w_do_exit;
  logic [3:0]       w_digit;
  logic [6:0]       w_seg;
  logic             w_lz_blank;
  logic [6:0]       w_y_next;
  logic [3:0]       w_control_next;

  always_comb begin
    w_state_next      = r_state;
    w_idx_next        = r_idx;
    w_cnt_next        = r_cnt;
    w_shadow_next     = r_shadow;
    w_frame_done_next = 1'b0;
    w_do_exit         = 1'b0;

    case (r_state)
      IDLE: begin
        if (en) begin
          w_shadow_next = digits;
          w_idx_next    = 2'd0;
          w_cnt_next    = '0;
          w_state_next  = SHOW;
        end
      end
      SHOW: begin
        if (r_cnt == P_LAST) begin
          w_cnt_next = '0;
          if (BLANK_CYC == 0) w_do_exit = 1'b1;
          else                w_state_next = BLANK;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      BLANK: begin
        if (r_cnt == B_LAST) begin
          w_cnt_next = '0;
          w_do_exit  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase

    // End of a digit slot: advance, or close the frame and resample en/digits.
    if (w_do_exit) begin
      if (r_idx != 2'd3) begin
        w_idx_next   = r_idx + 2'd1;
        w_state_next = SHOW;
      end else begin
        w_frame_done_next = 1'b1;
        w_idx_next        = 2'd0;
        if (en) begin
          w_shadow_next = digits;
          w_state_next  = SHOW;
        end else begin
          w_state_next = IDLE;
        end
      end
    end
  end

  // Outputs are registered, so decode the digit that will be lit next cycle.
  assign w_digit = w_shadow_next[{w_idx_next, 2'b00} +: 4];

  seg7_decode u_decode (
    .i_bcd (w_digit),
    .o_seg (w_seg)
  );

`ifdef SEG_LZ_BLANK_EN
  logic [3:0] w_hi_zero;
  for (genvar gi = 0; gi < 4; gi++) begin : g_lz
    assign w_hi_zero[gi] = (w_shadow_next[15:4*gi] == '0);
  end
  assign w_lz_blank = (w_idx_next != 2'd0) && w_hi_zero[w_idx_next];
`else
  assign w_lz_blank = 1'b0;
`endif

  assign w_control_next = (w_state_next == SHOW) ? ~(4'b0001 << w_idx_next) : ANODE_OFF;
  assign w_y_next       = ((w_state_next == SHOW) && !w_lz_blank) ? w_seg : SEG_BLANK;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_idx        <= 2'd0;
      r_cnt        <= '0;
      r_shadow     <= 16'h0000;
      r_y          <= SEG_BLANK;
      r_control    <= ANODE_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_cnt        <= w_cnt_next;
      r_shadow     <= w_shadow_next;
      r_y          <= w_y_next;
      r_control    <= w_control_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  assign y          = r_y;
  assign control    = r_control;
  assign frame_done = r_frame_done;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexing scheduler that shares one active-low 7-segment bus across four common-anode digits. It holds a frame-stable shadow copy of a 16-bit BCD word. It steps through digits 0 to 3, each with a programmable on-time followed by a blanking gap that suppresses ghosting. It sits between the counter/datapath blocks that produce BCD values and the board's segment/anode pins, replacing hard-wired single-digit control.

Parameters:
PRESCALE, 50000, clk cycles each digit is lit; must be at least 1.
BLANK_CYC, 16, clk cycles all anodes are off between digits; 0 means no blanking gap.
CNT_W, 17, width of the internal dwell counter; must hold max(PRESCALE, BLANK_CYC) - 1.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous, active-low reset.
en  in  1  scan enable; sampled only at a frame boundary or from IDLE.
digits  in  16  BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
y  out  7  segment drive, active-low, registered.
control  out  4  anode drive, active-low one-cold, registered; bit i selects digit i.
frame_done  out  1  one-cycle pulse at the end of digit 3's blanking gap.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, idx=0, cnt=0, shadow=0, y=7'b1111111, control=4'b1111, frame_done=0. Reset overrides every other input and aborts a scan mid-digit.
- States: IDLE, SHOW, BLANK. All outputs are registered and take their new value on the same edge that enters the state.
- IDLE:
  - Outputs are off.
  - If en==1: shadow<=digits, idx<=0, cnt<=0, enter SHOW. On the next cycle control=4'b1110.
- SHOW:
  - control = ~(4'b0001<<idx); y = decode(shadow[idx]).
  - cnt increments each cycle. When cnt==PRESCALE-1: cnt<=0, enter BLANK. If BLANK_CYC==0, take the BLANK exit action directly instead.
- BLANK:
  - control=4'b1111, y=7'b1111111.
  - When cnt==BLANK_CYC-1, take the exit action:
    - If idx<3: idx<=idx+1, enter SHOW.
    - If idx==3: frame_done<=1 for one cycle and idx wraps to 0. Then if en==1: shadow<=digits, enter SHOW. If en==0: enter IDLE.
- Timing:
  - Digit period is PRESCALE+BLANK_CYC cycles.
  - Frame period is 4*(PRESCALE+BLANK_CYC) cycles.
- Changes on digits mid-frame are invisible until the next frame boundary; there is no tearing.
- Deasserting en mid-frame lets the frame complete, then the block enters IDLE.
- Decode table (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000
  - Non-BCD values 10..15 give 1111111 (blank), never all-on.
- Simultaneous events: frame_done and shadow reload occur on the same edge. en rising while in BLANK has no effect before the frame boundary.

Optional Feature:
SEG_LZ_BLANK_EN
- Defined: leading-zero suppression. Digit i (i=3..1) shows 1111111 when shadow digit i and all higher shadow digits are 0. Digit 0 is always displayed. The anode is still driven, so timing is unchanged.
- Undefined: every digit is decoded normally; 0x0042 displays "0042".

Decomposition:
- Package seg_pkg:
  - state enum {IDLE, SHOW, BLANK}.
  - SEG_BLANK=7'b1111111 and ANODE_OFF=4'b1111.
  - SEG_CODE[0:9] constant array.
- Sub-module seg7_decode: combinational 4-bit BCD to 7-bit active-low, blank for values above 9. It is reusable by existing counter blocks.
- Scan FSM, dwell counter and shadow register stay in seg_scan_ctrl.

Test Plan:
- Reset check (PRESCALE=4, BLANK_CYC=2): rst=0 for 3 cycles with en=1 -> y=1111111, control=1111, frame_done=0 throughout.
- Basic scan: digits=16'h1234, en=1 from reset release -> control sequence 1110 x4, 1111 x2, 1101 x4, 1111 x2, 1011 x4, 1111 x2, 0111 x4, 1111 x2. Required y values are 0011001, 0110000, 0100100, 1111001 in the lit windows. frame_done is high for exactly 1 cycle at the end of the last 1111 window.
- Shadow stability: change digits to 16'h9999 during digit 1 of the frame -> digits 2 and 3 still show 2 and 1. The next frame shows 0011000 on all digits.
- Stop and invalid values: digits=16'hFA05, en dropped mid-frame -> the frame completes with digit 0 = 0010010, digit 1 = 1000000, and digits 2 and 3 = 1111111. The block then enters IDLE with control=1111.
- Reset mid-SHOW: rst=0 while control=1011 -> outputs off on the next edge. After release with en=1, the scan restarts at control=1110.
- SEG_LZ_BLANK_EN: digits=16'h0042 -> digits 3 and 2 show 1111111 with anodes still driven (0111, 1011). 16'h0000 shows 1000000 on digit 0 only. With the macro undefined, 16'h0042 shows 1000000 on digits 3 and 2.
